btn_event_gen: RTL and testbench

Consumes the debounced level from the button debouncer and converts it into one-cycle event pulses: press, release, short-press, long-press and auto-repeat. It sits directly downstream of the debouncer in the 25 MHz domain. UI logic (test-pattern select, cursor stepping) then acts on discrete events instead of raw levels.

---
 rtl/btn_event_gen_pkg.sv | 9 +
 rtl/btn_event_gen.sv | 73 +++++++
 tb/tb_btn_event_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/btn_event_gen_pkg.sv
// btn_event_gen_pkg: shared state type for the button event generator
package btn_event_gen_pkg;
  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } state_e;
endpackage

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns a debounced button level into press/release/short/long/repeat pulses
module btn_event_gen
  import btn_event_gen_pkg::*;
#(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  localparam int LONG_CYCLES   = (CLK_FREQ / 1000) * LONG_PRESS_MS;
  localparam int REPEAT_CYCLES = (CLK_FREQ / 1000) * REPEAT_MS;
  localparam int MAX_CYCLES    = LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW            = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
  localparam bit REPEAT_EN = REPEAT_MS != 0;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] ev_q, ev_d;
  logic active;
  assign active = state_q == PRESSED || state_q == LONG;
  assign {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held} = ev_q;
  // state, counter and registered event outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_REL;
      cnt_q   <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end
  // next state; the shared counter restarts on every state entry and never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_REL: if (!btn_in) begin state_d = IDLE; cnt_d = '0; end
      IDLE:     if (btn_in) begin state_d = PRESSED; cnt_d = '0; end
      PRESSED: begin
        state_d = !btn_in ? IDLE : (cnt_q == LONG_LAST ? LONG : PRESSED);
        cnt_d   = (!btn_in || cnt_q == LONG_LAST) ? '0 : cnt_q + 1'b1;
      end
      LONG: begin
        state_d = btn_in ? LONG : IDLE;
        cnt_d   = (!btn_in || !REPEAT_EN || cnt_q == REP_LAST) ? '0 : cnt_q + 1'b1;
      end
      default: begin state_d = WAIT_REL; cnt_d = '0; end
    endcase
  end
  // event pulses for the next cycle; a release on a threshold cycle suppresses long/repeat
  always_comb begin
    ev_d = {
      state_q == IDLE && btn_in,
      active && !btn_in,
      state_q == PRESSED && !btn_in,
      state_q == PRESSED && btn_in && cnt_q == LONG_LAST,
      REPEAT_EN && state_q == LONG && btn_in && cnt_q == REP_LAST,
      btn_in && (state_q == IDLE || active)
    };
  end
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: vector table, directed corner sequences and random stimulus vs a run-length model
module tb_btn_event_gen;
  localparam int L = 10;
  logic clk = 0, rst = 1, btn_in = 0;
  logic [5:0] out_a, out_b;
  int n_vec = 0, n_bad = 0;
  int run [2];
  bit armed [2];
  int rep_a = 0, rep_b = 0, long_a = 0;
  typedef struct {
    logic r;
    logic b;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  btn_event_gen #(.CLK_FREQ(1000), .LONG_PRESS_MS(10), .REPEAT_MS(4)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .press_pulse(out_a[5]), .release_pulse(out_a[4]), .short_pulse(out_a[3]),
    .long_pulse(out_a[2]), .repeat_pulse(out_a[1]), .held(out_a[0])
  );
  btn_event_gen #(.CLK_FREQ(1000), .LONG_PRESS_MS(10), .REPEAT_MS(0)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .press_pulse(out_b[5]), .release_pulse(out_b[4]), .short_pulse(out_b[3]),
    .long_pulse(out_b[2]), .repeat_pulse(out_b[1]), .held(out_b[0])
  );

  // Model: run = number of consecutive high samples since the press was accepted.
  // Outputs {press, release, short, long, repeat, held} expected after the edge.
  task automatic ref_step(input int i, input logic r, input logic b, output logic [5:0] e);
    int rc;
    rc = (i == 0) ? 4 : 0;
    e = '0;
    if (r) begin
      armed[i] = 0;
      run[i] = 0;
    end else if (!armed[i]) begin
      armed[i] = !b;
    end else if (b) begin
      run[i]++;
      e[5] = run[i] == 1;
      e[2] = run[i] == L + 1;
      e[1] = rc > 0 && run[i] > L + 1 && (run[i] - L - 1) % rc == 0;
      e[0] = 1;
    end else begin
      e[4] = run[i] > 0;
      e[3] = run[i] > 0 && run[i] <= L;
      run[i] = 0;
    end
  endtask

  task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b (press,rel,short,long,rep,held)", nm, $time, got, exp);
    end
  endtask

  task automatic check_n(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic b);
    logic [5:0] ea, eb;
    rst = r;
    btn_in = b;
    @(posedge clk);
    #1;
    ref_step(0, r, b, ea);
    ref_step(1, r, b, eb);
    check("dut_a", out_a, ea);
    check("dut_b", out_b, eb);
    rep_a += int'(out_a[1]);
    rep_b += int'(out_b[1]);
    long_a += int'(out_a[2]);
  endtask

  task automatic press(input int n);
    for (int k = 0; k < n; k++) step(0, 1);
    step(0, 0);
    step(0, 0);
  endtask

  initial begin
    logic [5:0] ea, eb;
    bit v;
    tbl[0]  = '{1, 0, 6'b000000};
    tbl[1]  = '{1, 1, 6'b000000};
    tbl[2]  = '{0, 1, 6'b000000};
    tbl[3]  = '{0, 0, 6'b000000};
    tbl[4]  = '{0, 1, 6'b100001};
    tbl[5]  = '{0, 1, 6'b000001};
    tbl[6]  = '{0, 0, 6'b011000};
    tbl[7]  = '{0, 0, 6'b000000};
    tbl[8]  = '{0, 1, 6'b100001};
    tbl[9]  = '{0, 0, 6'b011000};
    tbl[10] = '{0, 0, 6'b000000};
    for (int t = 0; t < 11; t++) begin
      rst = tbl[t].r;
      btn_in = tbl[t].b;
      @(posedge clk);
      #1;
      ref_step(0, tbl[t].r, tbl[t].b, ea);
      ref_step(1, tbl[t].r, tbl[t].b, eb);
      check($sformatf("tbl%0d_a", t), out_a, tbl[t].exp);
      check($sformatf("tbl%0d_b", t), out_b, eb);
    end
    press(5);
    rep_a = 0; rep_b = 0; long_a = 0;
    press(20);
    check_n("rep_count_a_20", rep_a, 2);
    check_n("long_count_a_20", long_a, 1);
    press(9);
    long_a = 0;
    press(10);
    check_n("race_no_long", long_a, 0);
    press(11);
    check_n("long_after_11", long_a, 1);
    rep_a = 0; rep_b = 0;
    press(30);
    check_n("rep_count_b_30", rep_b, 0);
    check_n("rep_count_a_30", rep_a, 4);
    press(15);
    step(1, 1);
    step(1, 1);
    for (int k = 0; k < 8; k++) step(0, 1);
    step(0, 0);
    step(0, 0);
    press(3);
    rep_a = 0;
    for (int k = 0; k < 13; k++) step(0, 1);
    step(1, 1);
    for (int k = 0; k < 4; k++) step(0, 1);
    check_n("rep_after_reset", rep_a, 0);
    step(0, 0);
    press(2);
    v = 0;
    for (int s = 0; s < 150; s++) begin
      int len;
      len = $urandom_range(1, 30);
      v = ~v;
      for (int k = 0; k < len; k++) step($urandom_range(0, 199) == 0, v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
